// File: rtl/control_sequencer.sv
// Four-state instruction sequencer driving ALU controls and acc/mem/PC strobes.
// Optional macro ILLEGAL_TRAP_EN: illegal opcodes halt and raise 'illegal' instead of acting as NOPs.
module control_sequencer #(
  parameter int OPW = 5,
  parameter int RCW = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [OPW-1:0] opcode,
  input  logic           zr,
  input  logic           ng,
  output logic           zx,
  output logic           nx,
  output logic           zy,
  output logic           ny,
  output logic           f,
  output logic           no,
  output logic           ir_load,
  output logic           load_acc,
  output logic           load_mem,
  output logic           pc_load,
  output logic           pc_inc,
  output logic           busy,
  output logic           halted,
  output logic [RCW-1:0] retired
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic           illegal
`endif
);

  // state  | meaning
  // IDLE   | waiting for start after reset
  // FETCH  | instruction register loads
  // DECODE | ALU controls registered from opcode
  // EXEC   | ALU computes with held controls
  // WRITE  | result/PC strobes issued, flags sampled
  // HALT   | stopped by 0x17 (or trapped illegal), waiting for start
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] DECODE = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] WRITE  = 3'd4;
  localparam logic [2:0] HALT   = 3'd5;

  localparam logic [4:0] OP_HALT = 5'h17;

  logic [2:0]     r_state;
  logic [2:0]     w_next;
  logic [5:0]     r_alu;
  logic [OPW-1:0] r_op;
  logic [RCW-1:0] r_retired;
  logic [6:0]     w_map;
  logic           w_dec_hit;
  logic           w_op_illegal;
  logic           w_load_acc;
  logic           w_load_mem;
  logic           w_pc_load;
  logic           w_pc_inc;

  function automatic logic is_illegal(input logic [OPW-1:0] op);
    logic [4:0] low;
    low = op[4:0];
    return ((op >> 5) != '0) || (low > 5'h19);
  endfunction

  // {hit, zx, nx, zy, ny, f, no}; hit = 0 leaves the controls untouched
  function automatic logic [6:0] alu_map(input logic [4:0] op);
    case (op)
      5'h00: return 7'b1_101010;
      5'h01: return 7'b1_111111;
      5'h02: return 7'b1_111010;
      5'h03: return 7'b1_001100;
      5'h04: return 7'b1_110001;
      5'h05: return 7'b1_001101;
      5'h06: return 7'b1_100001;
      5'h07: return 7'b1_001111;
      5'h08: return 7'b1_110011;
      5'h09: return 7'b1_011111;
      5'h0A: return 7'b1_110111;
      5'h0B: return 7'b1_001110;
      5'h0C: return 7'b1_110010;
      5'h0D: return 7'b1_000010;
      5'h0E: return 7'b1_010011;
      5'h0F: return 7'b1_000111;
      5'h10: return 7'b1_000000;
      5'h11: return 7'b1_010101;
      5'h12: return 7'b1_101010;
      5'h13: return 7'b1_101010;
      default: return 7'b0_000000;
    endcase
  endfunction

  assign w_map        = alu_map(opcode[4:0]);
  assign w_dec_hit    = w_map[6] && !is_illegal(opcode);
  assign w_op_illegal = is_illegal(r_op);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = FETCH;
      FETCH:   w_next = DECODE;
      DECODE:  w_next = EXEC;
      EXEC:    w_next = WRITE;
      WRITE: begin
        w_next = FETCH;
        if (!w_op_illegal && (r_op[4:0] == OP_HALT)) w_next = HALT;
`ifdef ILLEGAL_TRAP_EN
        if (w_op_illegal) w_next = HALT;
`endif
      end
      HALT:    if (start) w_next = FETCH;
      default: w_next = IDLE;
    endcase
  end

  // Strobes decode from the registered state and opcode so the flags are only looked at in WRITE
  always_comb begin
    w_load_acc = 1'b0;
    w_load_mem = 1'b0;
    w_pc_load  = 1'b0;
    w_pc_inc   = 1'b0;
    if (r_state == WRITE) begin
      if (w_op_illegal) begin
`ifndef ILLEGAL_TRAP_EN
        w_pc_inc = 1'b1;
`endif
      end else if (r_op[4:0] <= 5'h12) begin
        w_load_acc = 1'b1;
        w_pc_inc   = 1'b1;
      end else begin
        case (r_op[4:0])
          5'h13: begin
            w_load_mem = 1'b1;
            w_pc_inc   = 1'b1;
          end
          5'h14: w_pc_load = 1'b1;
          5'h15: begin
            w_pc_load = zr;
            w_pc_inc  = !zr;
          end
          5'h16: begin
            w_pc_load = ng;
            w_pc_inc  = !ng;
          end
          5'h18: begin
            w_pc_load = !zr;
            w_pc_inc  = zr;
          end
          5'h19: begin
            w_pc_load = !ng;
            w_pc_inc  = ng;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_alu     <= '0;
      r_op      <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == DECODE) begin
        r_op <= opcode;
        if (w_dec_hit) r_alu <= w_map[5:0];
      end
      if (r_state == WRITE) r_retired <= r_retired + RCW'(1);
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic r_illegal;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_illegal <= 1'b0;
    end else if ((r_state == WRITE) && w_op_illegal) begin
      r_illegal <= 1'b1;
    end else if ((r_state == HALT) && start) begin
      r_illegal <= 1'b0;
    end
  end
  assign illegal = r_illegal;
`endif

  assign {zx, nx, zy, ny, f, no} = r_alu;
  assign ir_load  = (r_state == FETCH);
  assign busy     = (r_state == FETCH) || (r_state == DECODE) ||
                    (r_state == EXEC)  || (r_state == WRITE);
  assign halted   = (r_state == HALT);
  assign load_acc = w_load_acc;
  assign load_mem = w_load_mem;
  assign pc_load  = w_pc_load;
  assign pc_inc   = w_pc_inc;
  assign retired  = r_retired;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed, table-driven bench for control_sequencer; a second RCW=4 instance checks counter wrap.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  opcode;
  logic        zr;
  logic        ng;
  logic        zx, nx, zy, ny, f, no;
  logic        ir_load, load_acc, load_mem, pc_load, pc_inc, busy, halted;
  logic [15:0] retired;
  logic        d4_zx, d4_nx, d4_zy, d4_ny, d4_f, d4_no;
  logic        d4_ir_load, d4_load_acc, d4_load_mem, d4_pc_load, d4_pc_inc, d4_busy, d4_halted;
  logic [3:0]  d4_retired;
`ifdef ILLEGAL_TRAP_EN
  logic        illegal;
  logic        d4_illegal;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int exp_ret  = 0;

  always #5 clk = ~clk;

  control_sequencer #(.OPW(5), .RCW(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .zr(zr), .ng(ng),
    .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
    .ir_load(ir_load), .load_acc(load_acc), .load_mem(load_mem),
    .pc_load(pc_load), .pc_inc(pc_inc), .busy(busy), .halted(halted),
    .retired(retired)
`ifdef ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  control_sequencer #(.OPW(5), .RCW(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .zr(zr), .ng(ng),
    .zx(d4_zx), .nx(d4_nx), .zy(d4_zy), .ny(d4_ny), .f(d4_f), .no(d4_no),
    .ir_load(d4_ir_load), .load_acc(d4_load_acc), .load_mem(d4_load_mem),
    .pc_load(d4_pc_load), .pc_inc(d4_pc_inc), .busy(d4_busy), .halted(d4_halted),
    .retired(d4_retired)
`ifdef ILLEGAL_TRAP_EN
    , .illegal(d4_illegal)
`endif
  );

  typedef struct {
    logic [4:0] op;
    logic       z;
    logic       n;
    logic [5:0] alu;  // zx nx zy ny f no
    logic [3:0] stb;  // load_acc load_mem pc_load pc_inc
  } vec_t;

  vec_t vecs[17];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] stb_now();
    return {load_acc, load_mem, pc_load, pc_inc};
  endfunction

  function automatic logic [5:0] alu_now();
    return {zx, nx, zy, ny, f, no};
  endfunction

  // Called while the DUT sits in FETCH; returns after the WRITE edge.
  task automatic run_instr(input logic [4:0] op, input logic z, input logic n,
                           input logic [5:0] alu, input logic [3:0] stb, input logic to_halt);
    opcode = op;
    zr = z;
    ng = n;
    chk("fetch_ir_load", 16'(ir_load), 16'd1);
    chk("fetch_strobes", 16'(stb_now()), 16'd0);
    tick();
    chk("decode_ir_load", 16'(ir_load), 16'd0);
    tick();
    chk("exec_alu", 16'(alu_now()), 16'(alu));
    chk("exec_strobes", 16'(stb_now()), 16'd0);
    tick();
    chk("write_strobes", 16'(stb_now()), 16'(stb));
    chk("write_busy", 16'(busy), 16'd1);
    tick();
    exp_ret++;
    chk("retired", retired, 16'(exp_ret));
    chk("retired_rcw4", 16'(d4_retired), 16'(exp_ret % 16));
    chk("after_strobes", 16'(stb_now()), 16'd0);
    chk("after_halted", 16'(halted), 16'(to_halt));
    chk("after_ir_load", 16'(ir_load), 16'(!to_halt));
  endtask

  initial begin
    vecs[0]  = '{5'h00, 1'b0, 1'b0, 6'b101010, 4'b1001};
    vecs[1]  = '{5'h07, 1'b1, 1'b0, 6'b001111, 4'b1001};
    vecs[2]  = '{5'h12, 1'b0, 1'b1, 6'b101010, 4'b1001};
    vecs[3]  = '{5'h0D, 1'b0, 1'b0, 6'b000010, 4'b1001};
    vecs[4]  = '{5'h13, 1'b0, 1'b0, 6'b101010, 4'b0101};
    vecs[5]  = '{5'h15, 1'b1, 1'b0, 6'b101010, 4'b0010};
    vecs[6]  = '{5'h15, 1'b0, 1'b1, 6'b101010, 4'b0001};
    vecs[7]  = '{5'h16, 1'b0, 1'b1, 6'b101010, 4'b0010};
    vecs[8]  = '{5'h16, 1'b1, 1'b0, 6'b101010, 4'b0001};
    vecs[9]  = '{5'h19, 1'b0, 1'b0, 6'b101010, 4'b0010};
    vecs[10] = '{5'h19, 1'b0, 1'b1, 6'b101010, 4'b0001};
    vecs[11] = '{5'h18, 1'b0, 1'b0, 6'b101010, 4'b0010};
    vecs[12] = '{5'h18, 1'b1, 1'b0, 6'b101010, 4'b0001};
    vecs[13] = '{5'h14, 1'b1, 1'b1, 6'b101010, 4'b0010};
    vecs[14] = '{5'h04, 1'b0, 1'b0, 6'b110001, 4'b1001};
    vecs[15] = '{5'h0A, 1'b1, 1'b1, 6'b110111, 4'b1001};
    vecs[16] = '{5'h11, 1'b0, 1'b0, 6'b010101, 4'b1001};

    rst_n = 1'b0;
    start = 1'b1;
    opcode = 5'h00;
    zr = 1'b0;
    ng = 1'b0;
    tick();
    tick();
    chk("rst_alu", 16'(alu_now()), 16'd0);
    chk("rst_strobes", 16'(stb_now()), 16'd0);
    chk("rst_ir_load", 16'(ir_load), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_halted", 16'(halted), 16'd0);
    chk("rst_retired", retired, 16'd0);

    rst_n = 1'b1;
    tick();
    chk("start_busy", 16'(busy), 16'd1);
    start = 1'b0;

    for (int i = 0; i < 17; i++) begin
      run_instr(vecs[i].op, vecs[i].z, vecs[i].n, vecs[i].alu, vecs[i].stb, 1'b0);
    end

    // Illegal opcode: controls keep the last mapped value (0x11)
`ifdef ILLEGAL_TRAP_EN
    run_instr(5'h1F, 1'b0, 1'b0, 6'b010101, 4'b0000, 1'b1);
    chk("trap_illegal", 16'(illegal), 16'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("trap_restart_ir", 16'(ir_load), 16'd1);
    chk("trap_illegal_clr", 16'(illegal), 16'd0);
`else
    run_instr(5'h1F, 1'b0, 1'b0, 6'b010101, 4'b0001, 1'b0);
`endif

    run_instr(5'h17, 1'b1, 1'b1, 6'b010101, 4'b0000, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("halt_hold", 16'({halted, busy, ir_load}), 16'b100);
      chk("halt_strobes", 16'(stb_now()), 16'd0);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("halt_restart_halted", 16'(halted), 16'd0);
    chk("halt_restart_ir", 16'(ir_load), 16'd1);

    // Reset during EXEC of a store aborts it with no load_mem
    opcode = 5'h13;
    tick();
    tick();
    chk("abort_in_exec", 16'(busy), 16'd1);
    rst_n = 1'b0;
    tick();
    exp_ret = 0;
    chk("abort_load_mem", 16'(load_mem), 16'd0);
    chk("abort_busy", 16'(busy), 16'd0);
    chk("abort_retired", retired, 16'd0);
    tick();
    chk("abort_load_mem2", 16'(load_mem), 16'd0);
    chk("abort_alu_clr", 16'(alu_now()), 16'd0);
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      run_instr(5'h00, 1'b0, 1'b0, 6'b101010, 4'b1001, 1'b0);
    end
    chk("wrap_rcw4_zero", 16'(d4_retired), 16'd0);
    chk("wrap_rcw16", retired, 16'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Parametrised, clocked successor to the single-cycle opcode decoder.
- Runs each instruction as a 4-state FETCH/DECODE/EXEC/WRITE sequence.
- Drives the ALU control bits and the accumulator, memory and PC strobes.
- Sits between the instruction register and the ALU/PC datapath.
- Adds over the previous decoder: registered outputs, an explicit HALT state (no simulator finish), two new conditional jumps, and illegal-opcode handling.

Parameters:
- OPW, 5, opcode width; must be >= 5. Any non-zero bit above bit 4 makes the opcode illegal.
- RCW, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  leave IDLE or HALT and begin fetching.
- opcode  input  OPW  instruction-register opcode; valid from DECODE onward.
- zr  input  1  ALU zero flag.
- ng  input  1  ALU negative flag.
- zx, nx, zy, ny, f, no  output  1 each  registered ALU control bits.
- ir_load  output  1  load instruction register.
- load_acc  output  1  write ALU result to accumulator.
- load_mem  output  1  write ALU result to memory.
- pc_load  output  1  load PC with jump target.
- pc_inc  output  1  increment PC.
- busy  output  1  high in FETCH/DECODE/EXEC/WRITE.
- halted  output  1  high in HALT.
- retired  output  RCW  count of completed instructions.

Behaviour:
- Reset: clk is a single clock; rst_n is synchronous, active-low. Sampled low at a clk edge, it forces the state to IDLE and clears every output and retired to 0. Reset mid-instruction aborts with no strobe issued.
- States and transitions:
  - IDLE: go to FETCH when start = 1.
  - FETCH: go to DECODE.
  - DECODE: go to EXEC.
  - EXEC: go to WRITE.
  - WRITE: go to FETCH, or to HALT for opcode 0x17. With ILLEGAL_TRAP_EN, an illegal opcode also goes to HALT.
  - HALT: go to FETCH when start = 1 (halted clears); otherwise hold.
  - start is ignored while busy.
- Latency: 4 cycles per instruction.
- FETCH: ir_load = 1 for exactly that cycle.
- DECODE: ALU controls are registered from the map below. They hold through EXEC and WRITE and keep their value in IDLE and HALT.
- ALU map, opcode: zx nx zy ny f no
  - 00:101010, 01:111111, 02:111010, 03:001100, 04:110001
  - 05:001101, 06:100001, 07:001111, 08:110011, 09:011111
  - 0A:110111, 0B:001110, 0C:110010, 0D:000010, 0E:010011
  - 0F:000111, 10:000000, 11:010101, 12:101010, 13:101010
  - Opcodes 0x14-0x19 and illegal opcodes leave the controls unchanged, so zr/ng still reflect the previous ALU result.
- WRITE strobes (one cycle each; pc_load and pc_inc are never both high):
  - 0x00-0x12: load_acc = 1, pc_inc = 1.
  - 0x13: load_mem = 1, pc_inc = 1.
  - 0x14: pc_load = 1 (unconditional jump).
  - 0x15: pc_load = 1 if zr, else pc_inc = 1.
  - 0x16: pc_load = 1 if ng, else pc_inc = 1.
  - 0x18 (new): pc_load = 1 if !zr, else pc_inc = 1.
  - 0x19 (new): pc_load = 1 if !ng, else pc_inc = 1.
  - 0x17: no strobe; enter HALT.
  - Opcode >= 0x1A, or any non-zero bit above bit 4: illegal.
- zr/ng are sampled in WRITE only.
- retired increments by 1 at the end of each WRITE, including halt and illegal opcodes. It wraps modulo 2^RCW.
- Outside their stated cycles, all strobes are 0.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in WRITE issues no strobe, enters HALT, and sets output illegal (1 bit). illegal clears on reset or on a start out of HALT.
- Undefined: an illegal opcode is a NOP (pc_inc = 1, no other strobe). The illegal port does not exist.

Test Plan:
- Reset/start: rst_n = 0 for 2 cycles with start = 1 -> all outputs 0, retired = 0. Release rst_n with start = 1 -> ir_load high exactly 1 cycle later, busy = 1.
- Opcode 0x00: -> zx..no = 101010 from DECODE. load_acc and pc_inc high in WRITE only; retired = 1 after 4 cycles.
- Opcode 0x15: zr = 1 -> pc_load = 1, pc_inc = 0. Repeat with zr = 0 -> pc_inc = 1. Repeat with opcode 0x19 and ng = 0 -> pc_load = 1.
- Opcode 0x17: -> no strobe, halted = 1, busy = 0, state holds 10 cycles. Then start = 1 -> FETCH, halted = 0.
- Opcode 0x1F: without macro -> pc_inc = 1 and the next instruction fetches. With ILLEGAL_TRAP_EN -> illegal = 1, halted = 1.
- rst_n = 0 during EXEC of opcode 0x13: -> load_mem never asserts; IDLE next cycle. RCW = 4 with 16 instructions run -> retired wraps to 0.
